e1_qres_buffer: RTL and testbench
=================================

// Module: e1_qres_buffer
// PURPOSE
//  Downstream stage of the E1 fixed-point adder: captures every adder result (c/c_valid pulse),
//  requantizes it from Q(N_IN-Q_IN).Q_IN to Q(N_OUT-Q_OUT).Q_OUT with round-half-up and
//  overflow handling, and buffers results in a show-ahead FIFO drained via valid/ready.
//  Adder has no backpressure; results arriving while full are dropped and counted.
// PARAMETERS
//  N_IN    64  total input width (adder N+Q: 15 int + 49 frac)
//  Q_IN    49  input fractional bits
//  N_OUT   24  total output width
//  Q_OUT   12  output fractional bits (Q_OUT <= Q_IN, N_OUT-Q_OUT <= N_IN-Q_IN)
//  DEPTH    8  FIFO entries, power of two, >= 2
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  c          in   N_IN           adder result, two's complement
//  c_valid    in   1              c valid this cycle (single-cycle pulse, no ready)
//  out_data   out  N_OUT          head-of-FIFO requantized result
//  out_valid  out  1              FIFO non-empty
//  out_ready  in   1              consumer accepts out_data when out_valid&out_ready
//  level      out  $clog2(DEPTH)+1 entries held
//  ovf        out  1              sticky: some accepted result exceeded output range
//  drop_cnt   out  16             results lost to full FIFO, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_data=0, level=0, ovf=0, drop_cnt=0, stage empty, ptrs=0.
//  Stage 1 (edge where c_valid=1): SH=Q_IN-Q_OUT; r = (c + (1<<(SH-1))) >>> SH (sign-extended, no
//   internal overflow); range check r against [-2^(N_OUT-1), 2^(N_OUT-1)-1]; register value+ovf bit.
//   SH=0: no rounding add.
//  Stage 2: stage-valid writes FIFO on next edge; latency c_valid edge -> out_valid high = 2 cycles.
//  Pop when out_valid&out_ready; push+pop same cycle: both occur, level unchanged (also when full).
//  Full and stage-valid without pop: entry dropped, drop_cnt+1 (saturating), level stays DEPTH.
//  ovf sets when an overflowing value enters stage 1 (including later-dropped ones); clears only on rst.
//  Pointers wrap modulo DEPTH; data order strictly FIFO; out_data undefined-free: holds head entry,
//   0 after reset.
//  Back-to-back c_valid every cycle sustained; rst mid-stream discards stage and FIFO contents.
// CONFIGURATION
//  E1_QRES_SAT_EN defined: overflowing values clamp to 2^(N_OUT-1)-1 / -2^(N_OUT-1).
//  Not defined: overflowing values wrap (keep low N_OUT bits of r). ovf flag behaves identically.
// STRUCTURE
//  Package e1_fixed_pkg: width localparams (E1_N_IN, E1_Q_IN), rounding shift constant,
//   function sat_narrow() for range check/clamp; shared with adder bench.
//  Sub-module e1_sync_fifo #(W, DEPTH): show-ahead FIFO with push/pop/full/empty/level;
//   top holds requantize stage, overflow flag and drop counter.
// TESTING
//  Defaults; bench uses fixedToFloat-style real conversion for checking.
//  c=1.5*2^49, out_ready=1 -> out_data=24'h001800 two cycles later, ovf=0.
//  c=2^36 -> 24'h000001; c=-2^36 -> 24'h000000; c=-3*2^36 -> 24'hFFFFFF (round-half-up).
//  c=3000.0*2^49 -> SAT_EN: 24'h7FFFFF, else 24'hBB8000; ovf=1 both builds.
//  out_ready=0, 10 consecutive c_valid (values 1..10 LSB-aligned) -> level=8, drop_cnt=2;
//   then out_ready=1 -> values 1..8 in order, out_valid low after 8th pop.
//  FIFO full, c_valid and pop same cycle -> level stays 8, drop_cnt unchanged, new value at tail.
//  rst pulsed (between edges) with level=5 -> out_valid=0, level=0, ovf=0 before next edge.

Source files
------------

// File: rtl/e1_fixed_pkg.sv
// rtl/e1_fixed_pkg.sv - E1 fixed-point widths, rounding shift and output range check
package e1_fixed_pkg;

   localparam int E1_N_IN    = 64;
   localparam int E1_Q_IN    = 49;
   localparam int E1_N_OUT   = 24;
   localparam int E1_Q_OUT   = 12;
   localparam int E1_RND_SH  = E1_Q_IN - E1_Q_OUT;
   // Working width for range checks; wide enough for any supported input width plus guard bit.
   localparam int E1_WIDE    = 128;

   typedef enum logic [1:0] {
      NARROW_OK = 2'd0,
      NARROW_HI = 2'd1,
      NARROW_LO = 2'd2
   } narrow_e;

   // Classifies a sign-extended value against the signed n_out-bit range; the caller clamps or wraps.
   function automatic narrow_e sat_narrow(input logic signed [E1_WIDE-1:0] r, input int n_out);
      logic signed [E1_WIDE-1:0] lim;
      logic signed [E1_WIDE-1:0] hi_lim;
      logic signed [E1_WIDE-1:0] lo_lim;
      lim    = E1_WIDE'(1) << (n_out - 1);
      hi_lim = lim - E1_WIDE'(1);
      lo_lim = -lim;
      if (r > hi_lim)
         sat_narrow = NARROW_HI;
      else if (r < lo_lim)
         sat_narrow = NARROW_LO;
      else
         sat_narrow = NARROW_OK;
   endfunction

endpackage

// File: rtl/e1_sync_fifo.sv
// rtl/e1_sync_fifo.sv - show-ahead synchronous FIFO with level and full/empty flags
module e1_sync_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO is only honoured when a pop frees the head slot in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign head  = mem[rd_ptr];

   // Storage array, cleared on reset so the head reads zero until the first write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks net occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/e1_qres_buffer.sv
// rtl/e1_qres_buffer.sv - requantize adder results and buffer them; E1_QRES_SAT_EN selects clamp over wrap
module e1_qres_buffer
   import e1_fixed_pkg::*;
#(
   parameter int N_IN  = E1_N_IN,
   parameter int Q_IN  = E1_Q_IN,
   parameter int N_OUT = E1_N_OUT,
   parameter int Q_OUT = E1_Q_OUT,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_IN-1:0]            c,
   input  logic                       c_valid,
   output logic [N_OUT-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf,
   output logic [15:0]                drop_cnt
);

   localparam int SH = Q_IN - Q_OUT;
   // Half an output LSB in input units; the extra low bit makes SH == 0 yield zero with no special case.
   localparam logic [N_IN+1:0] HALF_W = (N_IN + 2)'(1) << SH;
   localparam logic [N_IN:0]   HALF   = HALF_W[N_IN+1:1];

   logic signed [N_IN:0]      c_ext;
   logic signed [N_IN:0]      c_sum;
   logic signed [N_IN:0]      r_sh;
   logic signed [E1_WIDE-1:0] r_wide;
   narrow_e                   range;
   logic [N_OUT-1:0]          q_val;
   logic                      q_ovf;

   logic                      stage_valid;
   logic [N_OUT-1:0]          stage_data;
   logic                      stage_ovf;

   logic                      full;
   logic                      empty;
   logic                      pop;
   logic                      push;
   logic                      drop;

   // One guard bit above the input keeps the rounding add free of internal overflow.
   assign c_ext  = {c[N_IN-1], c};
   assign c_sum  = c_ext + HALF;
   assign r_sh   = c_sum >>> SH;
   assign r_wide = {{(E1_WIDE - N_IN - 1){r_sh[N_IN]}}, r_sh};
   assign range  = sat_narrow(r_wide, N_OUT);
   assign q_ovf  = (range != NARROW_OK);

`ifdef E1_QRES_SAT_EN
   localparam logic [N_OUT-1:0] Q_MAX = {1'b0, {(N_OUT - 1){1'b1}}};
   localparam logic [N_OUT-1:0] Q_MIN = {1'b1, {(N_OUT - 1){1'b0}}};

   // Out-of-range results clamp to the nearest representable output.
   always_comb begin
      q_val = r_sh[N_OUT-1:0];
      if (range == NARROW_HI)
         q_val = Q_MAX;
      else if (range == NARROW_LO)
         q_val = Q_MIN;
   end
`else
   // Out-of-range results wrap by keeping the low output bits.
   always_comb begin
      q_val = r_sh[N_OUT-1:0];
   end
`endif

   // Requantize stage: captures each adder pulse together with its overflow indication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_valid <= 1'b0;
         stage_data  <= '0;
         stage_ovf   <= 1'b0;
      end else begin
         stage_valid <= c_valid;
         if (c_valid) begin
            stage_data <= q_val;
            stage_ovf  <= q_ovf;
         end
      end
   end

   assign pop  = out_valid & out_ready;
   assign push = stage_valid & (~full | pop);
   assign drop = stage_valid & full & ~pop;

   // Sticky overflow covers every staged result, whether or not the FIFO had room for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (stage_valid && stage_ovf)
         ovf <= 1'b1;
   end

   // Saturating count of results discarded because the FIFO was full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end

   e1_sync_fifo #(
      .W     (N_OUT),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (stage_data),
      .pop       (pop),
      .head      (out_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign out_valid = ~empty;

endmodule

// File: tb/tb_e1_qres_buffer.sv
// tb/tb_e1_qres_buffer.sv - self-checking bench for e1_qres_buffer with a real-arithmetic reference model
module tb_e1_qres_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] c;
   logic        c_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic        out_valid;
   logic [3:0]  level;
   logic        ovf;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   logic [23:0] mq[$];
   bit          m_stage_v;
   logic [23:0] m_stage_d;
   bit          m_stage_o;
   bit          m_ovf;
   int          m_drop;

   e1_qres_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .c         (c),
      .c_valid   (c_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .ovf       (ovf),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: interpret c as a real number, scale to output LSBs, round half up, then range-handle.
   function automatic logic [23:0] ref_q(input longint cv, output bit ov);
      real v;
      real s;
      int  r;
      v  = real'(cv) / (2.0 ** 49);
      s  = $floor(v * 4096.0 + 0.5);
      r  = int'(s);
      ov = (r > 8388607) || (r < -8388608);
`ifdef E1_QRES_SAT_EN
      if (r > 8388607)
         r = 8388607;
      else if (r < -8388608)
         r = -8388608;
`endif
      ref_q = r[23:0];
   endfunction

   task automatic model_reset();
      mq.delete();
      m_stage_v = 0;
      m_stage_d = '0;
      m_stage_o = 0;
      m_ovf     = 0;
      m_drop    = 0;
   endtask

   // Advance model and DUT by one edge using the inputs present now, then compare.
   task automatic tick();
      bit          pop;
      bit          ov;
      logic [23:0] nd;
      pop = (mq.size() > 0) && out_ready;
      if (pop)
         void'(mq.pop_front());
      if (m_stage_v) begin
         if (m_stage_o)
            m_ovf = 1;
         if (mq.size() < 8)
            mq.push_back(m_stage_d);
         else if (m_drop < 65535)
            m_drop++;
      end
      if (c_valid) begin
         nd        = ref_q(longint'(c), ov);
         m_stage_v = 1;
         m_stage_d = nd;
         m_stage_o = ov;
      end else begin
         m_stage_v = 0;
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("level", 64'(level), 64'(mq.size()));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("ovf", 64'(ovf), 64'(m_ovf));
      if (mq.size() > 0)
         check("out_data", 64'(out_data), 64'(mq[0]));
   endtask

   // Single result with the consumer ready: visible two edges after the pulse.
   task automatic send_one(input logic [63:0] v, input string tag, input logic [23:0] exp);
      c       = v;
      c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
      tick();
      check(tag, 64'(out_data), 64'(exp));
      tick();
   endtask

   function automatic logic [63:0] rand_c();
      longint x;
      int     s;
      x = {$urandom, $urandom};
      x = (x <<< 14) >>> 14;
      s = $urandom_range(0, 12);
      return 64'(x <<< s);
   endfunction

   initial begin
      rst       = 1'b1;
      c         = '0;
      c_valid   = 1'b0;
      out_ready = 1'b1;
      model_reset();
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      send_one(64'd3 << 48, "dir_1p5", 24'h001800);
      check("dir_1p5_ovf", 64'(ovf), 64'd0);
      send_one(64'd1 << 36, "dir_half_up", 24'h000001);
      send_one(-(64'd1 << 36), "dir_neg_half", 24'h000000);
      send_one(-(64'd3 << 36), "dir_neg_1p5", 24'hFFFFFF);
`ifdef E1_QRES_SAT_EN
      send_one(64'd3000 << 49, "dir_ovf_val", 24'h7FFFFF);
`else
      send_one(64'd3000 << 49, "dir_ovf_val", 24'hBB8000);
`endif
      check("dir_ovf_flag", 64'(ovf), 64'd1);

      out_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         c       = 64'(k) << 37;
         c_valid = 1'b1;
         tick();
      end
      c_valid = 1'b0;
      tick();
      check("full_level", 64'(level), 64'd8);
      check("full_drop", 64'(drop_cnt), 64'd2);
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         check("drain_order", 64'(out_data), 64'(k));
         tick();
      end
      check("drain_empty", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         c       = 64'(20 + k) << 37;
         c_valid = 1'b1;
         tick();
      end
      c_valid = 1'b0;
      tick();
      c       = 64'd99 << 37;
      c_valid = 1'b1;
      tick();
      c_valid   = 1'b0;
      out_ready = 1'b1;
      tick();
      check("pushpop_level", 64'(level), 64'd8);
      check("pushpop_drop", 64'(drop_cnt), 64'd2);
      for (int k = 0; k < 7; k++)
         tick();
      check("pushpop_tail", 64'(out_data), 64'd99);
      tick();

      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         c       = 64'(k) << 37;
         c_valid = 1'b1;
         tick();
      end
      c_valid = 1'b0;
      tick();
      check("prerst_level", 64'(level), 64'd5);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_level", 64'(level), 64'd0);
      check("midrst_ovf", 64'(ovf), 64'd0);
      check("midrst_drop", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      model_reset();

      for (int i = 0; i < 400; i++) begin
         c         = rand_c();
         c_valid   = ($urandom_range(0, 9) < 7);
         out_ready = $urandom_range(0, 1) != 0;
         tick();
      end
      c_valid   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++)
         tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
